// File: rtl/case_xform_pkg.sv
// case_xform_pkg: case-mode encodings, ASCII letter bounds and the byte case-mapping function.
package case_xform_pkg;

    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_UPPER = 2'd1;
    localparam logic [1:0] MODE_LOWER = 2'd2;
    localparam logic [1:0] MODE_SWAP  = 2'd3;

    localparam logic [7:0] ASC_UA = 8'h41;
    localparam logic [7:0] ASC_UZ = 8'h5A;
    localparam logic [7:0] ASC_LA = 8'h61;
    localparam logic [7:0] ASC_LZ = 8'h7A;

    function automatic logic [7:0] case_map(input logic [7:0] b, input logic [1:0] mode);
        logic up;
        logic lo;
        up = b >= ASC_UA && b <= ASC_UZ;
        lo = b >= ASC_LA && b <= ASC_LZ;
        return (lo && (mode == MODE_UPPER || mode == MODE_SWAP)) ? b - 8'h20 :
               (up && (mode == MODE_LOWER || mode == MODE_SWAP)) ? b + 8'h20 : b;
    endfunction

endpackage

// File: rtl/case_xform_fifo.sv
// case_xform_fifo: first-word-fall-through ring buffer with flush and an explicit occupancy counter.
module case_xform_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign do_pop = pop && count != '0;
    assign dout   = count != '0 ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: dout is masked to zero while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_case_xform.sv
// uart_case_xform: case-mapping byte stream stage between uart_rx and uart_tx,
// with FWFT buffering, flow-control flags and drop statistics.
module uart_case_xform
    import case_xform_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int CNT_W    = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    input  logic [1:0]       i_mode,
    input  logic             i_flush,
    input  logic             i_clr_stat,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic [CW-1:0]    o_count,
    output logic             o_almost_full,
    output logic             o_full,
    output logic             o_overflow,
    output logic [CNT_W-1:0] o_drop_cnt
);

    logic pop;
    logic push;
    logic drop;

    assign o_tx_valid    = o_count != '0;
    assign o_full        = o_count == CW'(DEPTH);
    assign o_almost_full = o_count >= CW'(AF_LEVEL);

    // A full buffer still accepts a byte when the head leaves on the same edge.
    assign pop  = o_tx_valid && i_tx_ready;
    assign push = i_rx_valid && !i_flush && (!o_full || pop);
    assign drop = i_rx_valid && !i_flush && o_full && !pop;

    case_xform_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (pop),
        .flush (i_flush),
        .din   (case_map(i_rx_data, i_mode)),
        .dout  (o_tx_data),
        .count (o_count)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_overflow <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            o_overflow <= i_clr_stat ? drop : o_overflow | drop;
            o_drop_cnt <= i_clr_stat ? CNT_W'(drop) :
                          (drop && o_drop_cnt != '1) ? o_drop_cnt + 1'b1 : o_drop_cnt;
        end
    end

endmodule

// File: tb/tb_uart_case_xform.sv
// tb_uart_case_xform: scoreboard bench for uart_case_xform (main DEPTH=16 instance plus a
// small CNT_W=2 instance for drop-counter saturation).
module tb_uart_case_xform;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [1:0] mode;
    logic       flush;
    logic       clr_stat;
    logic       tx_ready;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic [4:0] count;
    logic       af;
    logic       full;
    logic       ov;
    logic [7:0] drop_cnt;

    logic [7:0] tx_data2;
    logic       tx_valid2;
    logic [2:0] count2;
    logic       af2;
    logic       full2;
    logic       ov2;
    logic [1:0] drop_cnt2;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] plog[$];
    logic [7:0] m_drop;
    logic       m_ov;

    uart_case_xform #(.DEPTH(16), .AF_LEVEL(12), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_mode(mode), .i_flush(flush), .i_clr_stat(clr_stat),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
        .o_count(count), .o_almost_full(af), .o_full(full),
        .o_overflow(ov), .o_drop_cnt(drop_cnt)
    );

    uart_case_xform #(.DEPTH(4), .AF_LEVEL(3), .CNT_W(2)) dut_small (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_mode(mode), .i_flush(flush), .i_clr_stat(clr_stat),
        .o_tx_data(tx_data2), .o_tx_valid(tx_valid2), .i_tx_ready(tx_ready),
        .o_count(count2), .o_almost_full(af2), .o_full(full2),
        .o_overflow(ov2), .o_drop_cnt(drop_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_map(input logic [7:0] b, input logic [1:0] m);
        if (m[0] && b inside {[8'h61:8'h7a]}) return b ^ 8'h20;
        if (m[1] && b inside {[8'h41:8'h5a]}) return b ^ 8'h20;
        return b;
    endfunction

    // Reference model: checks the main instance mid-cycle and predicts the coming edge.
    always @(negedge clk) begin
        int  mc;
        logic p;
        logic d;
        if (rst) begin
            q.delete();
            m_drop = '0;
            m_ov   = 1'b0;
        end else begin
            mc = q.size();
            chk("valid", tx_valid, mc != 0);
            chk("count", count, mc);
            chk("full", full, mc == 16);
            chk("almost_full", af, mc >= 12);
            chk("overflow", ov, m_ov);
            chk("drop_cnt", drop_cnt, m_drop);
            if (mc != 0) chk("head", tx_data, q[0]);
            p = mc != 0 && tx_ready;
            d = rx_valid && !flush && mc == 16 && !p;
            if (flush) q.delete();
            else begin
                if (p) begin
                    plog.push_back(tx_data);
                    void'(q.pop_front());
                end
                if (rx_valid && (mc < 16 || p)) q.push_back(ref_map(rx_data, mode));
            end
            if (clr_stat) begin
                m_ov   = d;
                m_drop = {7'd0, d};
            end else if (d) begin
                m_ov = 1'b1;
                if (m_drop != 8'hff) m_drop = m_drop + 8'd1;
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic f, input logic c);
        @(posedge clk);
        #1;
        rx_valid = v;
        rx_data  = d;
        tx_ready = r;
        flush    = f;
        clr_stat = c;
    endtask

    logic [23:0] mode_tbl [4] = '{24'h615A35, 24'h415A35, 24'h617A35, 24'h417A35};

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = '0;
        mode = 2'd0;
        flush = 1'b0;
        clr_stat = 1'b0;
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;

        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            plog.delete();
            cyc(1, 8'h61, 1, 0, 0);
            cyc(1, 8'h5A, 1, 0, 0);
            cyc(1, 8'h35, 1, 0, 0);
            repeat (4) cyc(0, 0, 1, 0, 0);
            chk("mode_len", plog.size(), 3);
            if (plog.size() == 3) chk($sformatf("mode%0d_seq", m), {plog[0], plog[1], plog[2]}, mode_tbl[m]);
        end

        mode = 2'd0;
        for (int i = 0; i < 18; i++) begin
            cyc(1, 8'(i), 0, 0, 0);
            if (i == 11) chk("af_at_11", af, 0);
            if (i == 12) chk("af_at_12", af, 1);
        end
        cyc(0, 0, 0, 0, 0);
        chk("ovf_full", full, 1);
        chk("ovf_count", count, 16);
        chk("ovf_flag", ov, 1);
        chk("ovf_drops", drop_cnt, 2);

        cyc(1, 8'h55, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("pp_count", count, 16);
        chk("pp_drops", drop_cnt, 2);
        plog.delete();
        repeat (20) cyc(0, 0, 1, 0, 0);
        chk("pp_len", plog.size(), 16);
        if (plog.size() == 16) chk("pp_last", plog[15], 8'h55);
        chk("pp_empty", tx_valid, 0);

        mode = 2'd3;
        plog.delete();
        for (int i = 0; i < 80; i++) cyc(i % 2 == 0, 8'($urandom_range(0, 255)), 1'(i % 2), 0, 0);
        repeat (4) cyc(0, 0, 1, 0, 0);
        chk("bp_len", plog.size(), 40);
        chk("bp_drops", drop_cnt, 2);

        mode = 2'd1;
        for (int i = 0; i < 5; i++) cyc(1, 8'h61 + 8'(i), 0, 0, 0);
        cyc(1, 8'hAA, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("flush_count", count, 0);
        chk("flush_valid", tx_valid, 0);
        chk("flush_drops", drop_cnt, 2);
        for (int i = 0; i < 3; i++) cyc(1, 8'h41 + 8'(i), 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("load3_count", count, 3);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", tx_valid, 0);
        chk("arst_data", tx_data, 0);
        chk("arst_count", count, 0);
        chk("arst_full", full, 0);
        chk("arst_af", af, 0);
        chk("arst_ovf", ov, 0);
        chk("arst_drops", drop_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        mode = 2'd0;
        for (int i = 0; i < 9; i++) cyc(1, 8'(i), 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("sat_full", full2, 1);
        chk("sat_count", count2, 4);
        chk("sat_ovf", ov2, 1);
        chk("sat_drops", drop_cnt2, 3);
        cyc(1, 8'h77, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("clrdrop_drops", drop_cnt2, 1);
        chk("clrdrop_ovf", ov2, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("clr_drops", drop_cnt2, 0);
        chk("clr_ovf", ov2, 0);
        chk("small_head", tx_data2, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_case_xform.md
Name: uart_case_xform

Overview:
Parametrised byte-stream transformer between uart_rx and uart_tx. It replaces the fixed uppercase-only path.
- Accepts received bytes and applies a run-time selectable ASCII case mode.
- Buffers results in a configurable-depth first-word-fall-through (FWFT) FIFO.
- Presents bytes to the transmitter with a valid/ready handshake.
- Adds overflow accounting, an almost-full flag for RTS-style flow control, and a synchronous flush.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- AF_LEVEL, 12, o_almost_full asserts when occupancy >= AF_LEVEL; range 1..DEPTH.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  single-cycle strobe; i_rx_data is valid; no backpressure.
- i_mode  in  2  case mode: 0 pass, 1 upper, 2 lower, 3 swap.
- i_flush  in  1  synchronous FIFO clear.
- i_clr_stat  in  1  synchronous clear of o_overflow and o_drop_cnt.
- o_tx_data  out  8  head-of-FIFO byte.
- o_tx_valid  out  1  FIFO not empty.
- i_tx_ready  in  1  transmitter ready; a pop occurs when o_tx_valid && i_tx_ready.
- o_count  out  $clog2(DEPTH+1)  current occupancy.
- o_almost_full  out  1  occupancy >= AF_LEVEL.
- o_full  out  1  occupancy == DEPTH.
- o_overflow  out  1  sticky: at least one byte dropped.
- o_drop_cnt  out  CNT_W  dropped-byte count, saturating.

Behaviour:
Reset (async, i_rst=1): all outputs and internal state go to 0.
- o_tx_valid=0, o_tx_data=0, o_count=0.
- o_full=0, o_almost_full=0, o_overflow=0, o_drop_cnt=0.
- Pointers are cleared.
- Reset mid-stream discards all buffered bytes.

Case mapping is combinational on i_rx_data, with i_mode sampled in the accept cycle:
- upper: 0x61..0x7A map to byte-0x20.
- lower: 0x41..0x5A map to byte+0x20.
- swap: applies both rules above.
- pass: identity.
- All other bytes, including >=0x80, pass unchanged in every mode.

Push = i_rx_valid && (!o_full || pop).
- Full with a simultaneous pop: the byte is accepted and occupancy stays DEPTH.
- Full with no pop: the byte is dropped; o_overflow <= 1; o_drop_cnt increments, saturating at 2^CNT_W-1.

Latency and handshake:
- A byte strobed at edge N into an empty FIFO gives o_tx_valid=1 with o_tx_data=mapped byte after edge N.
- o_tx_data and o_tx_valid are held stable while o_tx_valid && !i_tx_ready.
- Pop advances the head at the clock edge.
- Push and pop in the same cycle with the FIFO non-empty: occupancy unchanged.
- Push and pop in the same cycle with the FIFO empty: no pop occurs, since o_tx_valid=0.

Pointers and flags:
- Read/write pointers are log2(DEPTH) bits and wrap naturally.
- o_count is tracked as a separate counter.
- o_full, o_almost_full and o_tx_valid are derived registered or from o_count; no combinational path from i_tx_ready to o_tx_valid.

i_flush:
- Next edge: pointers and count go to 0 and o_tx_valid=0.
- A push in the same cycle as a flush is discarded and not counted as a drop.
- Statistics are unaffected.

i_clr_stat:
- Clears o_overflow and o_drop_cnt.
- Simultaneous clear and drop: the result is o_overflow=1 and o_drop_cnt=1.

No byte is ever duplicated or reordered.

Decomposition:
- Package case_xform_pkg:
  - Mode constants MODE_PASS=2'd0, MODE_UPPER=2'd1, MODE_LOWER=2'd2, MODE_SWAP=2'd3.
  - ASCII bounds ASC_UA=8'h41, ASC_UZ=8'h5A, ASC_LA=8'h61, ASC_LZ=8'h7A.
  - Function case_map(byte, mode).
- One sub-module, case_xform_fifo: FWFT ring buffer with DEPTH, push/pop, flush, count.
- The top level holds the mapping, drop logic and statistics.

Test Plan:
- Mode sweep: strobe "aZ5" in each mode, i_tx_ready=1 -> TX sequence:
  - pass: 61 5A 35
  - upper: 41 5A 35
  - lower: 61 7A 35
  - swap: 41 7A 35
- Overflow, DEPTH=16, i_tx_ready=0: push 18 bytes 0x00..0x11 ->
  - o_full=1, o_count=16, o_overflow=1, o_drop_cnt=2.
  - o_almost_full asserts at the 12th push.
  - Drain yields 0x00..0x0F in order.
- Full with simultaneous push and pop: o_count=16; strobe 0x55 with i_tx_ready=1 in the same cycle ->
  - Accepted, o_count stays 16, o_drop_cnt unchanged.
  - 0x55 emerges last.
- Backpressure and wrap: 40 bytes streamed with i_tx_ready toggling 1/0 each cycle ->
  - All 40 bytes emitted in order, pointers wrap twice.
  - o_tx_data stable whenever ready is low.
- Drop-counter saturation, CNT_W=2, FIFO full: 5 drops -> o_drop_cnt=3. Then i_clr_stat in the same cycle as a drop -> o_drop_cnt=1, o_overflow=1.
- Reset and flush: load 5 bytes, then assert i_flush with a simultaneous push -> o_count=0, o_tx_valid=0, o_drop_cnt unchanged. Load 3 bytes, then async i_rst mid-cycle -> all outputs 0 immediately.
